// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Front-panel controller for a BCD stopwatch. Two raw push-buttons are
//   synchronized, debounced and turned into single press events, which drive
//   a four-state FSM that issues start/stop toggles and clear requests to the
//   stopwatch core and optionally freezes the displayed time (lap hold).
//
// Ports
//   clk        system clock (10 MHz nominal)
//   rst_n      asynchronous active-low reset
//   btn_ss     raw start/stop button, high = pressed, bouncing
//   btn_lap    raw lap/reset button, high = pressed, bouncing
//   time_in    live BCD time {hr_h,hr_l,min_h,min_l,sec_h,sec_l}
//   ss_pulse   one-cycle toggle request to the stopwatch start_stop input
//   clr_pulse  one-cycle clear request to the stopwatch
//   disp_time  BCD time for the display (frozen while in LAP)
//   run        stopwatch counting (RUN or LAP)
//   lap_hold   display frozen (LAP)
//   state      FSM state code
//
// Parameter
//   DB_CNT     debounce stability window in clk cycles, >= 1
// -----------------------------------------------------------------------------
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | cleared and stopped; lap button ignored
//   RUN   | counting, display follows live time
//   PAUSE | stopped, live time shown; lap button clears the stopwatch
//   LAP   | counting, display frozen at the captured lap time
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int DB_CNT = 200000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_ss,
   input  logic        btn_lap,
   input  logic [23:0] time_in,
   output logic        ss_pulse,
   output logic        clr_pulse,
   output logic [23:0] disp_time,
   output logic        run,
   output logic        lap_hold,
   output logic [1:0]  state
);

   localparam int CW = $clog2(DB_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   // bit 0 = start/stop button, bit 1 = lap button
   logic [1:0]    btn_raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    db_lvl;
   logic [1:0]    press;
   logic [CW-1:0] db_cnt [2];

   logic          ev_ss;
   logic          ev_lap;

   state_t        state_q;
   state_t        state_d;
   logic          ss_d;
   logic          clr_d;
   logic          run_d;
   logic          lap_hold_d;
   logic [23:0]   hold_q;
   logic [23:0]   hold_d;

   assign btn_raw = {btn_lap, btn_ss};

   // ------------------------------------------------------------------------
   // Two-flop synchronizers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // ------------------------------------------------------------------------
   // Debouncers. The counter runs only while the synchronized input disagrees
   // with the accepted level; any agreement restarts the window. The press
   // event is registered on the same edge the level rises, so it is exactly
   // one cycle wide and needs a debounced release before it can recur.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_lvl <= 2'b00;
         press  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync2[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_MAX) begin
               db_lvl[i] <= sync2[i];
               press[i]  <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign ev_ss  = press[0];
   assign ev_lap = press[1];

   // ------------------------------------------------------------------------
   // FSM next-state and registered-output logic. A start/stop event wins over
   // a simultaneous lap event; the lap event is then simply dropped.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ss_d    = 1'b0;
      clr_d   = 1'b0;
      hold_d  = hold_q;

      if (ev_ss) begin
         ss_d = 1'b1;
         case (state_q)
            IDLE:  state_d = RUN;
            RUN:   state_d = PAUSE;
            PAUSE: state_d = RUN;
            LAP:   state_d = PAUSE;
         endcase
      end else if (ev_lap) begin
         case (state_q)
            IDLE:  state_d = IDLE;
            RUN: begin
               state_d = LAP;
               hold_d  = time_in;
            end
            PAUSE: begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end
            LAP:   state_d = RUN;
         endcase
      end

      run_d      = (state_d == RUN) || (state_d == LAP);
      lap_hold_d = (state_d == LAP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ss_pulse  <= 1'b0;
         clr_pulse <= 1'b0;
         run       <= 1'b0;
         lap_hold  <= 1'b0;
         hold_q    <= 24'h000000;
      end else begin
         state_q   <= state_d;
         ss_pulse  <= ss_d;
         clr_pulse <= clr_d;
         run       <= run_d;
         lap_hold  <= lap_hold_d;
         hold_q    <= hold_d;
      end
   end

   assign state     = state_q;
   assign disp_time = lap_hold ? hold_q : time_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Bench for stopwatch_ctrl with DB_CNT = 4. A window-based reference model
//   (a button level flips once the last DB_CNT+1 synchronized samples all
//   disagree with it) plus a transition table is compared against the DUT on
//   every falling edge. Directed sequences and a vector table cover latency,
//   glitch rejection, lap freeze, clear, simultaneous presses and reset during
//   debounce; a random phase exercises everything else.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn_ss = 1'b0;
   logic        btn_lap = 1'b0;
   logic [23:0] time_in = 24'h000000;
   logic        ss_pulse;
   logic        clr_pulse;
   logic [23:0] disp_time;
   logic        run;
   logic        lap_hold;
   logic [1:0]  state;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   stopwatch_ctrl #(.DB_CNT(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_ss    (btn_ss),
      .btn_lap   (btn_lap),
      .time_in   (time_in),
      .ss_pulse  (ss_pulse),
      .clr_pulse (clr_pulse),
      .disp_time (disp_time),
      .run       (run),
      .lap_hold  (lap_hold),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // state codes: 0 idle, 1 run, 2 pause, 3 lap
   int          ns_ss  [4] = '{1, 2, 1, 2};
   int          ns_lap [4] = '{0, 3, 0, 1};
   logic [DB+2:0] h_ss, h_lap;   // raw samples, index 0 = newest
   int          m_state;
   bit          m_lvl_ss, m_lvl_lap, m_ev_ss, m_ev_lap;
   bit          m_ss_p, m_clr_p, m_run, m_lh;
   logic [23:0] m_hold;

   function automatic bit window_flips(input logic [DB+2:0] h, input bit lvl);
      // synchronizer delay of two edges: sample seen now is h[2]
      for (int j = 2; j <= DB + 2; j++) begin
         if (h[j] == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      h_ss = '0; h_lap = '0;
      m_state = 0;
      m_lvl_ss = 0; m_lvl_lap = 0; m_ev_ss = 0; m_ev_lap = 0;
      m_ss_p = 0; m_clr_p = 0; m_run = 0; m_lh = 0;
      m_hold = 24'h000000;
   endtask

   task automatic model_step();
      m_ss_p  = 0;
      m_clr_p = 0;
      if (m_ev_ss) begin
         m_ss_p  = 1;
         m_state = ns_ss[m_state];
      end else if (m_ev_lap) begin
         if (m_state == 2) m_clr_p = 1;
         if (m_state == 1) m_hold = time_in;
         m_state = ns_lap[m_state];
      end
      m_run = (m_state == 1) || (m_state == 3);
      m_lh  = (m_state == 3);

      h_ss  = {h_ss[DB+1:0], btn_ss};
      h_lap = {h_lap[DB+1:0], btn_lap};
      m_ev_ss  = 0;
      m_ev_lap = 0;
      if (window_flips(h_ss, m_lvl_ss)) begin
         m_lvl_ss = !m_lvl_ss;
         m_ev_ss  = m_lvl_ss;
      end
      if (window_flips(h_lap, m_lvl_lap)) begin
         m_lvl_lap = !m_lvl_lap;
         m_ev_lap  = m_lvl_lap;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_state", {30'd0, state}, m_state);
         check("m_ss_pulse", {31'd0, ss_pulse}, {31'd0, m_ss_p});
         check("m_clr_pulse", {31'd0, clr_pulse}, {31'd0, m_clr_p});
         check("m_run", {31'd0, run}, {31'd0, m_run});
         check("m_lap_hold", {31'd0, lap_hold}, {31'd0, m_lh});
         check("m_disp", {8'd0, disp_time}, {8'd0, (m_lh ? m_hold : time_in)});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   typedef struct {
      logic        ss;
      logic        lap;
      logic [23:0] tin;
      logic [1:0]  st;
      logic        rn;
      logic        lh;
      logic [23:0] disp;
      int          n_ss;
      int          n_clr;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int cnt_ss, cnt_clr, at;

      vecs[0]  = '{1'b0, 1'b1, 24'h000001, 2'd0, 1'b0, 1'b0, 24'h000001, 0, 0};
      vecs[1]  = '{1'b1, 1'b0, 24'h000002, 2'd1, 1'b1, 1'b0, 24'h000002, 1, 0};
      vecs[2]  = '{1'b1, 1'b0, 24'h000003, 2'd2, 1'b0, 1'b0, 24'h000003, 1, 0};
      vecs[3]  = '{1'b1, 1'b0, 24'h000004, 2'd1, 1'b1, 1'b0, 24'h000004, 1, 0};
      vecs[4]  = '{1'b0, 1'b1, 24'h012345, 2'd3, 1'b1, 1'b1, 24'h012345, 0, 0};
      vecs[5]  = '{1'b0, 1'b0, 24'h012346, 2'd3, 1'b1, 1'b1, 24'h012345, 0, 0};
      vecs[6]  = '{1'b0, 1'b1, 24'h012346, 2'd1, 1'b1, 1'b0, 24'h012346, 0, 0};
      vecs[7]  = '{1'b0, 1'b1, 24'h000100, 2'd3, 1'b1, 1'b1, 24'h000100, 0, 0};
      vecs[8]  = '{1'b1, 1'b0, 24'h000200, 2'd2, 1'b0, 1'b0, 24'h000200, 1, 0};
      vecs[9]  = '{1'b0, 1'b1, 24'h000300, 2'd0, 1'b0, 1'b0, 24'h000300, 0, 1};
      vecs[10] = '{1'b1, 1'b0, 24'h000400, 2'd1, 1'b1, 1'b0, 24'h000400, 1, 0};
      vecs[11] = '{1'b1, 1'b1, 24'h000500, 2'd2, 1'b0, 1'b0, 24'h000500, 1, 0};
      vecs[12] = '{1'b1, 1'b1, 24'h000600, 2'd1, 1'b1, 1'b0, 24'h000600, 1, 0};
      vecs[13] = '{1'b0, 1'b1, 24'h000700, 2'd3, 1'b1, 1'b1, 24'h000700, 0, 0};
      vecs[14] = '{1'b1, 1'b1, 24'h000800, 2'd2, 1'b0, 1'b0, 24'h000800, 1, 0};
      vecs[15] = '{1'b0, 1'b1, 24'h000900, 2'd0, 1'b0, 1'b0, 24'h000900, 0, 1};

      // reset values
      time_in = 24'h123456;
      rst_n = 1'b0;
      repeat (3) tick();
      chk_en = 1'b1;
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_run", {31'd0, run}, 32'd0);
      check("rst_lap_hold", {31'd0, lap_hold}, 32'd0);
      check("rst_ss_pulse", {31'd0, ss_pulse}, 32'd0);
      check("rst_clr_pulse", {31'd0, clr_pulse}, 32'd0);
      check("rst_disp", {8'd0, disp_time}, 32'h00123456);
      rst_n = 1'b1;
      tick();

      // press latency: single pulse at edge N+7, none while held
      btn_ss = 1'b1;
      cnt_ss = 0; at = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ss_pulse) begin cnt_ss++; at = i; end
      end
      check("lat_pulse_count", cnt_ss, 1);
      check("lat_pulse_edge", at, 7);
      check("lat_state", {30'd0, state}, 32'd1);
      check("lat_run", {31'd0, run}, 32'd1);
      btn_ss = 1'b0;
      repeat (12) tick();

      // glitch train 3 high / 1 low: never stable long enough
      cnt_ss = 0;
      for (int i = 0; i < 40; i++) begin
         btn_ss = (i % 4) != 3;
         tick();
         if (ss_pulse) cnt_ss++;
      end
      btn_ss = 1'b0;
      repeat (8) begin tick(); if (ss_pulse) cnt_ss++; end
      check("glitch_pulses", cnt_ss, 0);
      check("glitch_state", {30'd0, state}, 32'd1);

      // reset during debounce discards the pending press
      btn_ss = 1'b1;
      cnt_ss = 0;
      repeat (4) begin tick(); if (ss_pulse) cnt_ss++; end
      rst_n = 1'b0;
      repeat (2) begin tick(); if (ss_pulse || clr_pulse) cnt_ss++; end
      rst_n = 1'b1;
      check("rstdb_no_pulse", cnt_ss, 0);
      check("rstdb_state", {30'd0, state}, 32'd0);
      at = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ss_pulse) begin cnt_ss++; at = i; end
      end
      check("rstdb_pulse_count", cnt_ss, 1);
      check("rstdb_pulse_edge", at, 7);
      btn_ss = 1'b0;
      repeat (10) tick();

      // vector table from a fresh reset
      do_reset();
      foreach (vecs[v]) begin
         time_in = vecs[v].tin;
         btn_ss  = vecs[v].ss;
         btn_lap = vecs[v].lap;
         cnt_ss = 0; cnt_clr = 0;
         for (int i = 0; i < 22; i++) begin
            if (i == 10) begin btn_ss = 1'b0; btn_lap = 1'b0; end
            tick();
            if (ss_pulse)  cnt_ss++;
            if (clr_pulse) cnt_clr++;
         end
         check($sformatf("vec%0d_state", v), {30'd0, state}, {30'd0, vecs[v].st});
         check($sformatf("vec%0d_run", v), {31'd0, run}, {31'd0, vecs[v].rn});
         check($sformatf("vec%0d_lap_hold", v), {31'd0, lap_hold}, {31'd0, vecs[v].lh});
         check($sformatf("vec%0d_disp", v), {8'd0, disp_time}, {8'd0, vecs[v].disp});
         check($sformatf("vec%0d_ss_count", v), cnt_ss, vecs[v].n_ss);
         check($sformatf("vec%0d_clr_count", v), cnt_clr, vecs[v].n_clr);
      end

      // random phase, checked continuously against the model
      for (int s = 0; s < 300; s++) begin
         int len;
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
            rst_n = 1'b1;
         end
         btn_ss  = ($urandom_range(0, 2) == 0);
         btn_lap = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 0) time_in = 24'($urandom);
         len = $urandom_range(1, 10);
         repeat (len) tick();
      end
      btn_ss = 1'b0;
      btn_lap = 1'b0;
      repeat (12) tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DB_CNT, default 200000, debounce stability window in clk cycles (20 ms at 10 MHz); legal range >= 1.
REQ-002 SHALL have port clk  input  1  system clock, 10 MHz.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port btn_ss  input  1  raw start/stop push-button, asynchronous, bouncing, high = pressed.
REQ-005 SHALL have port btn_lap  input  1  raw lap/reset push-button, asynchronous, bouncing, high = pressed.
REQ-006 SHALL have port time_in  input  24  live BCD time from stopwatch, {hr_h,hr_l,min_h,min_l,sec_h,sec_l}.
REQ-007 SHALL have port ss_pulse  output  1  one-cycle toggle request to stopwatch start_stop.
REQ-008 SHALL have port clr_pulse  output  1  one-cycle request to stopwatch clear.
REQ-009 SHALL have port disp_time  output  24  BCD time for display.
REQ-010 SHALL have port run  output  1  high when the stopwatch is counting (states RUN, LAP).
REQ-011 SHALL have port lap_hold  output  1  high when disp_time is frozen (state LAP).
REQ-012 SHALL have port state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized button SHALL have its own debouncer: counter (width clog2(DB_CNT+1)) increments while synchronized value differs from debounced level, clears to 0 when equal; debounced level updates when counter reaches DB_CNT, counter then clears.
REQ-015 A press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; a held button yields exactly one event; a new event needs a debounced release first.
REQ-016 Glitches shorter than DB_CNT consecutive cycles SHALL produce no event and no debounced-level change.
REQ-017 Latency: with btn held high from rising edge N, ss_pulse (or resulting state change) SHALL appear at edge N+3+DB_CNT (2 sync + DB_CNT debounce + 1 FSM register).
REQ-018 FSM transitions (registered): IDLE+ss -> RUN, ss_pulse; IDLE+lap -> IDLE, no output.
REQ-019 RUN+ss -> PAUSE, ss_pulse; RUN+lap -> LAP, hold register captures time_in at that edge.
REQ-020 LAP+ss -> PAUSE, ss_pulse, display released to live; LAP+lap -> RUN, display released.
REQ-021 PAUSE+ss -> RUN, ss_pulse; PAUSE+lap -> IDLE, clr_pulse.
REQ-022 ss and lap events in the same cycle SHALL act on ss only; lap event discarded.
REQ-023 ss_pulse and clr_pulse SHALL be registered, exactly one cycle wide, never asserted together, never on consecutive cycles from one event.
REQ-024 disp_time SHALL equal hold register when lap_hold=1, else time_in (combinational mux, zero latency).
REQ-025 run and lap_hold SHALL be registered decodes consistent with state in the same cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=IDLE, ss_pulse=0, clr_pulse=0, run=0, lap_hold=0, hold register=0, synchronizers=0, debounce counters=0, debounced levels=0.
REQ-027 Reset mid-debounce SHALL discard the pending press; after release, a button already held SHALL need a full 2+DB_CNT cycles again to generate an event.
REQ-028 Reset SHALL NOT emit clr_pulse (stopwatch shares rst_n).

Verification (DB_CNT=4)
REQ-029 Reset: assert rst_n=0 -> state=0, run=0, lap_hold=0, ss_pulse=0, clr_pulse=0, disp_time=time_in.
REQ-030 btn_ss high from edge N for 20 cycles in IDLE -> single ss_pulse at edge N+7, state=1, run=1; no further pulse while held.
REQ-031 btn_ss toggling 3 high / 1 low for 40 cycles -> no ss_pulse, state unchanged.
REQ-032 RUN, time_in=24'h012345, press lap -> state=3, lap_hold=1; time_in then 24'h012346 -> disp_time stays 24'h012345; press lap -> state=1, disp_time=24'h012346.
REQ-033 PAUSE, press lap -> one-cycle clr_pulse, state=0, run=0; simultaneous ss+lap in RUN -> state=2, ss_pulse only, no clr_pulse.
REQ-034 btn_ss held, rst_n pulsed low at debounce count 2 -> no ss_pulse; after release, hold >= 6 cycles -> one ss_pulse 7 edges after the first edge sampled high.
